// File: rtl/xbee_api_rx.sv
// rtl/xbee_api_rx.sv - xBee API-mode UART receiver: 8N1 byte deserializer,
// 0x7E/length/checksum frame parser and a single-frame release buffer.
module xbee_api_rx #(
    parameter int BAUD_DIV = 347,
    parameter int MAX_LEN  = 32
) (
    input  logic       FAB_CLK,
    input  logic       M2F_RESET_N,
    input  logic       RX,
    output logic [7:0] FRAME_DATA,
    output logic       FRAME_VALID,
    input  logic       FRAME_READY,
    output logic       FRAME_LAST,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int CW = 16;
    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {F_HUNT, F_LEN_MSB, F_LEN_LSB, F_PAYLOAD, F_CSUM} fr_state_t;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            half_hit, full_hit, byte_stb, rx_ferr;

    fr_state_t       fr_state_q, fr_state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      sum_q, sum_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            full_q, full_d;
    logic            err_q, err_d;
    logic            ovr_q, ovr_d;
    logic            wr_en, commit, last_byte;
    logic [7:0]      csum_chk;
    logic [7:0]      mem [0:MAX_LEN-1];

    assign half_hit  = (baud_cnt_q == CW'(BAUD_DIV / 2 - 1));
    assign full_hit  = (baud_cnt_q == CW'(BAUD_DIV - 1));
    assign csum_chk  = sum_q + shift_q;
    assign last_byte = full_q && (8'(rd_ptr_q) == len_q - 8'd1);

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= R_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            fr_state_q <= F_HUNT;
            len_q      <= '0;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            fr_state_q <= fr_state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    // Byte receiver: start bit re-checked at its midpoint, then whole-bit steps.
    always_comb begin
        rx_state_d = rx_state_q;
        baud_cnt_d = baud_cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        case (rx_state_q)
            R_IDLE: begin
                baud_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = R_START;
                end
            end
            R_START: begin
                if (half_hit) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (full_hit) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end
                end
            end
            R_STOP: begin
                if (full_hit) begin
                    baud_cnt_d = '0;
                    rx_state_d = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        byte_stb = (rx_state_q == R_STOP) && full_hit && rx_sync_q;
        rx_ferr  = (rx_state_q == R_STOP) && full_hit && !rx_sync_q;
    end

    always_comb begin
        fr_state_d = fr_state_q;
        len_d      = len_q;
        sum_d      = sum_q;
        wr_ptr_d   = wr_ptr_q;
        wr_en      = 1'b0;
        commit     = 1'b0;
        err_d      = 1'b0;
        ovr_d      = 1'b0;
        if (byte_stb) begin
            if (shift_q == 8'h7E && fr_state_q != F_HUNT) begin
                err_d      = 1'b1;
                wr_ptr_d   = '0;
                fr_state_d = F_LEN_MSB;
            end else begin
                case (fr_state_q)
                    F_HUNT: begin
                        if (shift_q == 8'h7E) begin
                            fr_state_d = F_LEN_MSB;
                        end
                    end
                    F_LEN_MSB: begin
                        if (shift_q != 8'h00) begin
                            err_d      = 1'b1;
                            fr_state_d = F_HUNT;
                        end else begin
                            fr_state_d = F_LEN_LSB;
                        end
                    end
                    F_LEN_LSB: begin
                        if (shift_q == 8'h00 || shift_q > 8'(MAX_LEN)) begin
                            err_d      = 1'b1;
                            fr_state_d = F_HUNT;
                        end else if (full_q) begin
                            // Previous frame still draining: drop this one.
                            ovr_d      = 1'b1;
                            fr_state_d = F_HUNT;
                        end else begin
                            len_d      = shift_q;
                            sum_d      = 8'h00;
                            wr_ptr_d   = '0;
                            fr_state_d = F_PAYLOAD;
                        end
                    end
                    F_PAYLOAD: begin
                        wr_en    = 1'b1;
                        sum_d    = sum_q + shift_q;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (8'(wr_ptr_q) == len_q - 8'd1) begin
                            fr_state_d = F_CSUM;
                        end
                    end
                    F_CSUM: begin
                        if (csum_chk == 8'hFF) begin
                            commit = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        wr_ptr_d   = '0;
                        fr_state_d = F_HUNT;
                    end
                    default: fr_state_d = F_HUNT;
                endcase
            end
        end else if (rx_ferr && fr_state_q != F_HUNT) begin
            err_d      = 1'b1;
            wr_ptr_d   = '0;
            fr_state_d = F_HUNT;
        end
    end

    always_comb begin
        full_d   = full_q;
        rd_ptr_d = rd_ptr_q;
        if (full_q && FRAME_READY) begin
            if (last_byte) begin
                full_d   = 1'b0;
                rd_ptr_d = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
        if (commit) begin
            full_d   = 1'b1;
            rd_ptr_d = '0;
        end
    end

    always_comb begin
        FRAME_VALID = full_q;
        FRAME_DATA  = full_q ? mem[rd_ptr_q] : 8'h00;
        FRAME_LAST  = last_byte;
        FRAME_ERR   = err_q;
        OVERRUN     = ovr_q;
        BUSY        = (fr_state_q != F_HUNT) || full_q;
    end

endmodule

// File: tb/tb_xbee_api_rx.sv
// tb/tb_xbee_api_rx.sv - directed serial-frame bench for xbee_api_rx.
module tb_xbee_api_rx;

    localparam int BD = 16;

    logic       FAB_CLK = 1'b0;
    logic       M2F_RESET_N = 1'b0;
    logic       RX = 1'b1;
    logic [7:0] FRAME_DATA;
    logic       FRAME_VALID;
    logic       FRAME_READY = 1'b1;
    logic       FRAME_LAST;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    int vectors = 0;
    int miscompares = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    int cyc = 0;
    logic [7:0] cap_data [$];
    logic       cap_last [$];
    int         cap_cyc  [$];
    logic [7:0] seq [$];

    xbee_api_rx #(.BAUD_DIV(BD), .MAX_LEN(32)) dut (
        .FAB_CLK    (FAB_CLK),
        .M2F_RESET_N(M2F_RESET_N),
        .RX         (RX),
        .FRAME_DATA (FRAME_DATA),
        .FRAME_VALID(FRAME_VALID),
        .FRAME_READY(FRAME_READY),
        .FRAME_LAST (FRAME_LAST),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN),
        .BUSY       (BUSY)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    always @(posedge FAB_CLK) cyc <= cyc + 1;

    always @(negedge FAB_CLK) begin
        if (M2F_RESET_N) begin
            if (FRAME_ERR) err_cnt++;
            if (OVERRUN) ovr_cnt++;
            if (FRAME_VALID && FRAME_READY) begin
                cap_data.push_back(FRAME_DATA);
                cap_last.push_back(FRAME_LAST);
                cap_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cd(input int i);
        return (i < cap_data.size()) ? {24'h0, cap_data[i]} : 32'hBAD;
    endfunction

    function automatic logic [31:0] cl(input int i);
        return (i < cap_last.size()) ? {31'h0, cap_last[i]} : 32'hBAD;
    endfunction

    function automatic logic [31:0] cgap(input int i);
        return (i < cap_cyc.size() && i > 0) ? 32'(cap_cyc[i] - cap_cyc[i-1]) : 32'hBAD;
    endfunction

    task automatic bit_out(input logic v);
        @(posedge FAB_CLK) #1 RX = v;
        repeat (BD - 1) @(posedge FAB_CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop_bit);
        bit_out(1'b1);
    endtask

    task automatic send_seq(input logic [7:0] s [$]);
        foreach (s[i]) send_byte(s[i], 1'b1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge FAB_CLK);
        @(negedge FAB_CLK);
    endtask

    task automatic clear_mon();
        err_cnt = 0;
        ovr_cnt = 0;
        cap_data.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    initial begin
        // Reset values
        settle(4);
        check("rst_data",  {24'h0, FRAME_DATA}, 32'h00);
        check("rst_valid", {31'h0, FRAME_VALID}, 32'h0);
        check("rst_last",  {31'h0, FRAME_LAST}, 32'h0);
        check("rst_err",   {31'h0, FRAME_ERR}, 32'h0);
        check("rst_ovr",   {31'h0, OVERRUN}, 32'h0);
        check("rst_busy",  {31'h0, BUSY}, 32'h0);
        @(posedge FAB_CLK) #1 M2F_RESET_N = 1'b1;
        settle(2 * BD);

        // Good 3-byte frame, consumer always ready
        clear_mon();
        seq = '{8'h7E, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9F};
        send_seq(seq);
        settle(2 * BD);
        check("f1_count", 32'(cap_data.size()), 32'd3);
        check("f1_b0", cd(0), 32'h10);
        check("f1_b1", cd(1), 32'h20);
        check("f1_b2", cd(2), 32'h30);
        check("f1_last0", cl(0), 32'h0);
        check("f1_last1", cl(1), 32'h0);
        check("f1_last2", cl(2), 32'h1);
        check("f1_gap1", cgap(1), 32'd1);
        check("f1_gap2", cgap(2), 32'd1);
        check("f1_err", 32'(err_cnt), 32'd0);
        check("f1_busy", {31'h0, BUSY}, 32'h0);

        // Bad checksum
        clear_mon();
        seq = '{8'h7E, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'hA0};
        send_seq(seq);
        settle(2 * BD);
        check("csum_err", 32'(err_cnt), 32'd1);
        check("csum_count", 32'(cap_data.size()), 32'd0);

        // Oversize length, then a minimal good frame
        clear_mon();
        seq = '{8'h7E, 8'h00, 8'h21};
        send_seq(seq);
        settle(BD);
        check("len_err", 32'(err_cnt), 32'd1);
        check("len_busy", {31'h0, BUSY}, 32'h0);
        seq = '{8'h7E, 8'h00, 8'h01, 8'h55, 8'hAA};
        send_seq(seq);
        settle(2 * BD);
        check("len_err_after", 32'(err_cnt), 32'd1);
        check("len_count", 32'(cap_data.size()), 32'd1);
        check("len_b0", cd(0), 32'h55);
        check("len_last0", cl(0), 32'h1);

        // Held frame, second frame overruns, first drains intact
        clear_mon();
        FRAME_READY = 1'b0;
        seq = '{8'h7E, 8'h00, 8'h02, 8'h12, 8'h34, 8'hB9};
        send_seq(seq);
        settle(BD);
        check("hold_valid", {31'h0, FRAME_VALID}, 32'h1);
        check("hold_data", {24'h0, FRAME_DATA}, 32'h12);
        check("hold_last", {31'h0, FRAME_LAST}, 32'h0);
        check("hold_busy", {31'h0, BUSY}, 32'h1);
        seq = '{8'h7E, 8'h00, 8'h01, 8'h55, 8'hAA};
        send_seq(seq);
        settle(BD);
        check("ovr_cnt", 32'(ovr_cnt), 32'd1);
        check("ovr_err", 32'(err_cnt), 32'd0);
        check("ovr_data_stable", {24'h0, FRAME_DATA}, 32'h12);
        check("ovr_valid_stable", {31'h0, FRAME_VALID}, 32'h1);
        @(posedge FAB_CLK) #1 FRAME_READY = 1'b1;
        settle(2 * BD);
        check("drain_count", 32'(cap_data.size()), 32'd2);
        check("drain_b0", cd(0), 32'h12);
        check("drain_b1", cd(1), 32'h34);
        check("drain_last1", cl(1), 32'h1);
        check("drain_valid", {31'h0, FRAME_VALID}, 32'h0);
        check("drain_busy", {31'h0, BUSY}, 32'h0);

        // 0x7E inside payload restarts the frame
        clear_mon();
        seq = '{8'h7E, 8'h00, 8'h02, 8'h11, 8'h7E, 8'h00, 8'h01, 8'h42, 8'hBD};
        send_seq(seq);
        settle(2 * BD);
        check("abort_err", 32'(err_cnt), 32'd1);
        check("abort_count", 32'(cap_data.size()), 32'd1);
        check("abort_b0", cd(0), 32'h42);
        check("abort_last0", cl(0), 32'h1);

        // Framing error during payload
        clear_mon();
        seq = '{8'h7E, 8'h00, 8'h02, 8'h11};
        send_seq(seq);
        send_byte(8'h22, 1'b0);
        settle(2 * BD);
        check("ferr_err", 32'(err_cnt), 32'd1);
        check("ferr_count", 32'(cap_data.size()), 32'd0);
        check("ferr_busy", {31'h0, BUSY}, 32'h0);

        // Short low glitch on idle line is ignored, receiver still works
        clear_mon();
        @(posedge FAB_CLK) #1 RX = 1'b0;
        repeat (5) @(posedge FAB_CLK);
        #1 RX = 1'b1;
        settle(3 * BD);
        check("glitch_err", 32'(err_cnt), 32'd0);
        check("glitch_ovr", 32'(ovr_cnt), 32'd0);
        check("glitch_busy", {31'h0, BUSY}, 32'h0);
        seq = '{8'h7E, 8'h00, 8'h01, 8'h55, 8'hAA};
        send_seq(seq);
        settle(2 * BD);
        check("glitch_count", 32'(cap_data.size()), 32'd1);
        check("glitch_b0", cd(0), 32'h55);

        // Reset while a frame is waiting to drain
        clear_mon();
        FRAME_READY = 1'b0;
        seq = '{8'h7E, 8'h00, 8'h01, 8'h33, 8'hCC};
        send_seq(seq);
        settle(BD);
        check("pre_rst_valid", {31'h0, FRAME_VALID}, 32'h1);
        check("pre_rst_data", {24'h0, FRAME_DATA}, 32'h33);
        #1 M2F_RESET_N = 1'b0;
        settle(2);
        check("mid_rst_valid", {31'h0, FRAME_VALID}, 32'h0);
        check("mid_rst_data", {24'h0, FRAME_DATA}, 32'h00);
        check("mid_rst_busy", {31'h0, BUSY}, 32'h0);
        @(posedge FAB_CLK) #1 M2F_RESET_N = 1'b1;
        clear_mon();
        FRAME_READY = 1'b1;
        settle(2 * BD);
        check("post_rst_count", 32'(cap_data.size()), 32'd0);
        check("post_rst_err", 32'(err_cnt), 32'd0);
        check("post_rst_ovr", 32'(ovr_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xbee_api_rx.md
XBEE_API_RX -- requirements
Module: xbee_api_rx

Interface
REQ-001 Parameter BAUD_DIV, default 347, SHALL set FAB_CLK cycles per UART bit (40 MHz / 115200).
REQ-002 Parameter MAX_LEN, default 32, SHALL set the maximum accepted API frame-data length in bytes (range 1..255).
REQ-003 FAB_CLK  input  1  SHALL be the single fabric clock; all state changes on its rising edge.
REQ-004 M2F_RESET_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 RX  input  1  SHALL be the asynchronous UART serial input from the xBee: idle high, 8N1, LSB first.
REQ-006 FRAME_DATA  output  8  SHALL carry the current released frame-data byte.
REQ-007 FRAME_VALID  output  1  SHALL be high while FRAME_DATA holds a valid byte.
REQ-008 FRAME_READY  input  1  SHALL be the consumer acceptance signal for FRAME_DATA.
REQ-009 FRAME_LAST  output  1  SHALL be high with the final byte of a frame.
REQ-010 FRAME_ERR  output  1  SHALL be a 1-cycle pulse on any discarded frame.
REQ-011 OVERRUN  output  1  SHALL be a 1-cycle pulse when a frame is lost because the buffer is still draining.
REQ-012 BUSY  output  1  SHALL be high whenever the frame FSM is not in HUNT or the buffer is non-empty.

Function
REQ-013 RX SHALL pass through a 2-flop synchronizer before use.
REQ-014 Byte receiver FSM SHALL use states IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on a synchronized falling edge of RX.
REQ-016 START SHALL re-sample RX at BAUD_DIV/2 cycles: low -> DATA; high -> IDLE (glitch rejected, no error).
REQ-017 DATA SHALL sample 8 bits at BAUD_DIV-cycle intervals from the start-bit midpoint, shifting LSB first.
REQ-018 STOP SHALL sample once after BAUD_DIV cycles: high -> 1-cycle byte strobe, IDLE; low -> framing error, IDLE.
REQ-019 Frame FSM SHALL use states HUNT, LEN_MSB, LEN_LSB, PAYLOAD, CSUM; each byte strobe drives at most one transition.
REQ-020 HUNT SHALL ignore all bytes except 0x7E, which moves to LEN_MSB.
REQ-021 LEN_MSB non-zero -> FRAME_ERR, HUNT; zero -> LEN_LSB.
REQ-022 LEN_LSB of 0 or greater than MAX_LEN -> FRAME_ERR, HUNT; otherwise latch length, clear 8-bit sum, go to PAYLOAD.
REQ-023 PAYLOAD SHALL write each byte to the buffer at the write pointer and add it to the sum modulo 256; after length bytes, go to CSUM.
REQ-024 CSUM: (sum + byte) mod 256 == 0xFF -> commit frame for release; otherwise FRAME_ERR, rewind write pointer; both -> HUNT.
REQ-025 A 0x7E byte in LEN_MSB, LEN_LSB, PAYLOAD or CSUM SHALL abort the frame (FRAME_ERR, rewind) and move to LEN_MSB.
REQ-026 A framing error in any state other than HUNT SHALL produce FRAME_ERR, rewind, and move to HUNT.
REQ-027 The buffer SHALL hold one frame of MAX_LEN bytes; nothing is presented before commit.
REQ-028 After commit, bytes SHALL be presented in order; a byte transfers on a FAB_CLK edge with FRAME_VALID and FRAME_READY both high.
REQ-029 FRAME_DATA, FRAME_LAST and FRAME_VALID SHALL hold stable while FRAME_VALID is high and FRAME_READY is low.
REQ-030 FRAME_VALID SHALL go high the cycle after commit; transfer of the FRAME_LAST byte empties the buffer.
REQ-031 If LEN_LSB completes while the buffer is non-empty, the frame SHALL be dropped (OVERRUN pulse, HUNT); FRAME_ERR SHALL NOT pulse.
REQ-032 Byte reception SHALL continue during draining; no sample is missed.

Reset
REQ-033 While M2F_RESET_N is low: both FSMs SHALL be in IDLE/HUNT, buffer empty, synchronizer flops 1.
REQ-034 While M2F_RESET_N is low: FRAME_DATA = 0x00; FRAME_VALID, FRAME_LAST, FRAME_ERR, OVERRUN, BUSY = 0.
REQ-035 Reset asserted mid-frame or mid-drain SHALL discard all data; no output pulse SHALL follow deassertion.

Verification
REQ-036 Serial 7E 00 03 10 20 30 9F, READY = 1 -> 10, 20, 30 on consecutive cycles, FRAME_LAST with 30, no FRAME_ERR.
REQ-037 Same frame with checksum byte 0xA0 -> single FRAME_ERR pulse; FRAME_VALID stays 0.
REQ-038 7E 00 21 (33 > MAX_LEN) -> FRAME_ERR after LEN_LSB; then valid frame 7E 00 01 55 AA -> byte 55 with FRAME_LAST.
REQ-039 Valid frame held with READY = 0, second valid frame sent -> OVERRUN pulse; first frame drains intact once READY = 1.
REQ-040 7E 00 02 11 7E 00 01 42 BD -> one FRAME_ERR, then 42 delivered with FRAME_LAST.
REQ-041 Stop bit forced low during PAYLOAD -> FRAME_ERR; 0.3-bit low glitch on idle RX -> no output activity.
